// File: rtl/bmc_rx_pkg.sv
// Shared definitions for the BMC receiver: state encoding, default timing
// thresholds (in clk cycles at 12 MHz) and the interval counter width.
`timescale 1ns/1ps
package bmc_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } bmc_state_e;

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = 7'd127;

  localparam int DEF_T_MIN   = 12;
  localparam int DEF_T_SPLIT = 30;
  localparam int DEF_T_MAX   = 56;
  localparam int DEF_T_IDLE  = 64;
  localparam int DEF_N_LOCK  = 8;

  // True when an interval lies inside [lo, hi] inclusive.
  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/cc_sync.sv
// Two-flop synchronizer bringing the asynchronous CC comparator output into
// the clk domain. Both stages reset to 0.
`timescale 1ns/1ps
module cc_sync (
  input  logic clk,
  input  logic rstz,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next values simply shift the comparator level down the chain.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchronizer stages.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/bmc_rx.sv
// BMC receiver: measures the spacing between CC line transitions, trains on
// the preamble until N_LOCK consecutive legal intervals are seen, then
// decodes full-UI intervals as 0 and pairs of half-UI intervals as 1.
// A quiet line for T_IDLE cycles ends the reception.
`timescale 1ns/1ps
module bmc_rx
  import bmc_rx_pkg::*;
#(
  parameter int T_MIN   = DEF_T_MIN,
  parameter int T_SPLIT = DEF_T_SPLIT,
  parameter int T_MAX   = DEF_T_MAX,
  parameter int T_IDLE  = DEF_T_IDLE,
  parameter int N_LOCK  = DEF_N_LOCK
) (
  input  logic clk,
  input  logic rstz,
  input  logic comp_cc,
  input  logic rx_en,
  output logic rx_bit,
  output logic rx_bit_vld,
  output logic rx_eop,
  output logic rx_err,
  output logic rx_active,
  output logic cc_idle
);

  localparam int LOCK_W = $clog2(N_LOCK + 1);

  localparam logic [CNT_W-1:0]  L_MIN   = CNT_W'(T_MIN);
  localparam logic [CNT_W-1:0]  L_SPLIT = CNT_W'(T_SPLIT);
  localparam logic [CNT_W-1:0]  L_MAX   = CNT_W'(T_MAX);
  localparam logic [CNT_W-1:0]  L_IDLE  = CNT_W'(T_IDLE);
  localparam logic [LOCK_W-1:0] L_LAST  = LOCK_W'(N_LOCK - 1);

  logic cc_s;

  logic              cc_prev_q, cc_prev_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  bmc_state_e        state_q,   state_d;
  logic [LOCK_W-1:0] lock_q,    lock_d;
  logic              pend_q,    pend_d;
  logic              bit_q,     bit_d;
  logic              vld_q,     vld_d;
  logic              eop_q,     eop_d;
  logic              err_q,     err_d;
  logic              active_q,  active_d;
  logic              idle_q,    idle_d;

  logic edge_det;
  logic timeout;
  logic ivl_legal;
  logic ivl_full;
  logic ivl_half;

  cc_sync u_cc_sync (
    .clk  (clk),
    .rstz (rstz),
    .d    (comp_cc),
    .q    (cc_s)
  );

  // An edge is any change of the synchronized level; the interval counter
  // holds the cycles since the previous edge, so its value at an edge is the
  // measured interval. A timeout loses to a coincident edge.
  always_comb begin
    cc_prev_d = cc_s;
    edge_det  = cc_s ^ cc_prev_q;
    if (edge_det) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    timeout   = (cnt_q >= L_IDLE) && !edge_det;
    ivl_legal = in_range(cnt_q, L_MIN, L_MAX);
    ivl_full  = ivl_legal && (cnt_q >= L_SPLIT);
    ivl_half  = ivl_legal && (cnt_q <  L_SPLIT);
  end

  // Receive FSM: training, decode and termination; strobes default low.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    pend_d  = pend_q;
    bit_d   = bit_q;
    vld_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;

    if (!rx_en) begin
      state_d = ST_IDLE;
      lock_d  = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (edge_det) begin
            state_d = ST_TRAIN;
            lock_d  = '0;
            pend_d  = 1'b0;
          end
        end
        ST_TRAIN: begin
          if (edge_det) begin
            if (ivl_legal) begin
              if (lock_q == L_LAST) begin
                state_d = ST_DATA;
                lock_d  = '0;
                pend_d  = 1'b0;
              end else begin
                lock_d = lock_q + LOCK_W'(1);
              end
            end else begin
              lock_d = '0;
            end
          end else if (timeout) begin
            state_d = ST_IDLE;
            lock_d  = '0;
          end
        end
        ST_DATA: begin
          if (edge_det) begin
            if (ivl_full && !pend_q) begin
              bit_d = 1'b0;
              vld_d = 1'b1;
            end else if (ivl_half && pend_q) begin
              bit_d  = 1'b1;
              vld_d  = 1'b1;
              pend_d = 1'b0;
            end else if (ivl_half) begin
              pend_d = 1'b1;
            end else begin
              // Out-of-range interval, or a full UI while half a '1' is pending.
              err_d   = 1'b1;
              pend_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else if (timeout) begin
            eop_d   = 1'b1;
            err_d   = pend_q;
            pend_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          lock_d  = '0;
          pend_d  = 1'b0;
        end
      endcase
    end

    // Status outputs follow the registered state, so a terminating strobe is
    // still seen with cc_idle low and cc_idle rises on the following clk.
    active_d = (state_q == ST_TRAIN) || (state_q == ST_DATA);
    idle_d   = (state_q == ST_IDLE);
  end

  // All receiver state and registered outputs.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      cc_prev_q <= 1'b0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      lock_q    <= '0;
      pend_q    <= 1'b0;
      bit_q     <= 1'b0;
      vld_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
      active_q  <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      cc_prev_q <= cc_prev_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      lock_q    <= lock_d;
      pend_q    <= pend_d;
      bit_q     <= bit_d;
      vld_q     <= vld_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
      active_q  <= active_d;
      idle_q    <= idle_d;
    end
  end

  assign rx_bit     = bit_q;
  assign rx_bit_vld = vld_q;
  assign rx_eop     = eop_q;
  assign rx_err     = err_q;
  assign rx_active  = active_q;
  assign cc_idle    = idle_q;

endmodule

// File: tb/tb_bmc_rx.sv
// Bench for bmc_rx: drives CC transitions as lists of intervals, predicts
// bit/eop/err strobes and their cycle from an interval-level model, and
// compares against strobes recorded from the DUT.
`timescale 1ns/1ps
module tb_bmc_rx;

  localparam int T_MIN   = 12;
  localparam int T_SPLIT = 30;
  localparam int T_MAX   = 56;
  localparam int T_IDLE  = 64;
  localparam int N_LOCK  = 8;
  localparam int LAT     = 3;   // transition to registered strobe

  localparam int EV_BIT0 = 0;
  localparam int EV_BIT1 = 1;
  localparam int EV_EOP  = 2;
  localparam int EV_ERR  = 4;

  typedef struct {
    int cyc;
    int code;
    int idle;
  } ev_t;

  logic clk = 1'b0;
  logic rstz = 1'b0;
  logic comp_cc = 1'b0;
  logic rx_en = 1'b1;
  logic rx_bit, rx_bit_vld, rx_eop, rx_err, rx_active, cc_idle;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  int  ivls[$];
  ev_t exp_q[$];
  ev_t got_q[$];
  int  post_eop[$];
  int  gidx = 0;
  int  pidx = 0;
  bit  jit = 1'b0;
  logic eop_prev = 1'b0;

  bmc_rx #(
    .T_MIN(T_MIN), .T_SPLIT(T_SPLIT), .T_MAX(T_MAX),
    .T_IDLE(T_IDLE), .N_LOCK(N_LOCK)
  ) dut (
    .clk        (clk),
    .rstz       (rstz),
    .comp_cc    (comp_cc),
    .rx_en      (rx_en),
    .rx_bit     (rx_bit),
    .rx_bit_vld (rx_bit_vld),
    .rx_eop     (rx_eop),
    .rx_err     (rx_err),
    .rx_active  (rx_active),
    .cc_idle    (cc_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with its cycle and the cc_idle level seen with it.
  always @(negedge clk) begin
    if (rx_bit_vld) got_q.push_back('{cyc, rx_bit ? EV_BIT1 : EV_BIT0, int'(cc_idle)});
    if (rx_eop)     got_q.push_back('{cyc, EV_EOP, int'(cc_idle)});
    if (rx_err)     got_q.push_back('{cyc, EV_ERR, int'(cc_idle)});
    if (eop_prev)   post_eop.push_back(int'(cc_idle));
    eop_prev = rx_eop;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int code);
    exp_q.push_back('{c, code, 0});
  endtask

  // Interval-level reference: the packet starts from IDLE with its first
  // transition at c0; each list entry is the gap to the next transition.
  task automatic model_pkt(input int c0, input int mode);
    int  t;
    int  st;     // 0 idle, 1 training, 2 decoding
    int  lock;
    bit  pend;
    t = c0; st = 1; lock = 0; pend = 1'b0;
    foreach (ivls[i]) begin
      int v;
      v = ivls[i];
      if (st != 0 && v > T_IDLE) begin
        if (st == 2) begin
          push_ev(t + T_IDLE + LAT, EV_EOP);
          if (pend) push_ev(t + T_IDLE + LAT, EV_ERR);
        end
        st = 0;
      end
      t += v;
      if (st == 0) begin
        st = 1; lock = 0; pend = 1'b0;
      end else if (st == 1) begin
        if (v >= T_MIN && v <= T_MAX) begin
          lock++;
          if (lock == N_LOCK) begin st = 2; pend = 1'b0; end
        end else begin
          lock = 0;
        end
      end else begin
        if (v < T_MIN || v > T_MAX) begin
          push_ev(t + LAT, EV_ERR); st = 0; pend = 1'b0;
        end else if (v >= T_SPLIT) begin
          if (pend) begin push_ev(t + LAT, EV_ERR); st = 0; pend = 1'b0; end
          else push_ev(t + LAT, EV_BIT0);
        end else if (pend) begin
          push_ev(t + LAT, EV_BIT1); pend = 1'b0;
        end else begin
          pend = 1'b1;
        end
      end
    end
    if (mode == 0 && st == 2) begin
      push_ev(t + T_IDLE + LAT, EV_EOP);
      if (pend) push_ev(t + T_IDLE + LAT, EV_ERR);
    end
  endtask

  task automatic add_bit(input bit b);
    int h1, h2, f;
    h1 = 20 + (jit ? int'($urandom_range(2)) - 1 : 0);
    h2 = 20 + (jit ? int'($urandom_range(2)) - 1 : 0);
    f  = 40 + (jit ? int'($urandom_range(4)) - 2 : 0);
    if (b) begin ivls.push_back(h1); ivls.push_back(h2); end
    else   ivls.push_back(f);
  endtask

  task automatic add_preamble(input int nbits);
    for (int i = 0; i < nbits; i++) add_bit((i % 2) == 0);
  endtask

  task automatic compare_events();
    int n;
    n = got_q.size() - gidx;
    check_eq("event_count", n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      check_eq("event_cycle", got_q[gidx + i].cyc, exp_q[i].cyc);
      check_eq("event_kind", got_q[gidx + i].code, exp_q[i].code);
      check_eq("strobe_not_in_idle", got_q[gidx + i].idle, 0);
    end
    gidx = got_q.size();
    exp_q.delete();
    while (pidx < post_eop.size()) begin
      check_eq("cc_idle_after_eop", post_eop[pidx], 1);
      pidx++;
    end
    check_eq("end_idle_active", int'({cc_idle, rx_active}), 2);
  endtask

  // mode 0: line goes quiet; 1: rx_en dropped; 2: rstz pulsed.
  task automatic send_pkt(input int mode);
    int c0;
    @(posedge clk); #1 comp_cc = ~comp_cc; c0 = cyc;
    foreach (ivls[i]) begin
      repeat (ivls[i]) @(posedge clk);
      #1 comp_cc = ~comp_cc;
    end
    model_pkt(c0, mode);
    case (mode)
      1: begin
        repeat (10) @(posedge clk); #1 rx_en = 1'b0;
        repeat (80) @(posedge clk); #1 rx_en = 1'b1;
        repeat (5) @(posedge clk); #1;
      end
      2: begin
        repeat (10) @(posedge clk); #1 rstz = 1'b0;
        repeat (3) @(posedge clk); #1 rstz = 1'b1;
        repeat (100) @(posedge clk); #1;
      end
      default: begin
        repeat (T_IDLE + 16) @(posedge clk); #1;
      end
    endcase
    compare_events();
    ivls.delete();
  endtask

  initial begin
    // Reset held while the comparator toggles: idle status, no strobes.
    for (int k = 0; k < 6; k++) begin
      repeat (1 + $urandom_range(20)) @(posedge clk);
      #1 comp_cc = ~comp_cc;
      check_eq("reset_outputs",
               int'({cc_idle, rx_active, rx_bit_vld, rx_eop, rx_err, rx_bit}), 32);
    end
    comp_cc = 1'b0;
    repeat (3) @(posedge clk); #1 rstz = 1'b1;
    repeat (100) @(posedge clk); #1;
    check_eq("post_reset_idle", int'({cc_idle, rx_active}), 2);
    gidx = got_q.size();

    // Full 64-bit preamble, then quiet -> alternating bits and one eop.
    add_preamble(64); send_pkt(0);
    // 0, 1, then half + full with pend set -> error.
    add_preamble(16); add_bit(1'b0); add_bit(1'b1); ivls.push_back(20); ivls.push_back(40);
    send_pkt(0);
    // Out-of-range intervals in DATA.
    add_preamble(16); ivls.push_back(8);  send_pkt(0);
    add_preamble(16); ivls.push_back(60); send_pkt(0);
    add_preamble(16); ivls.push_back(11); send_pkt(0);
    add_preamble(16); ivls.push_back(57); send_pkt(0);
    // Edge exactly at the timeout cycle counts as an (illegal) edge.
    add_preamble(16); ivls.push_back(T_IDLE); send_pkt(0);
    // Threshold values decode.
    add_preamble(16);
    ivls.push_back(29); ivls.push_back(29); ivls.push_back(30);
    ivls.push_back(12); ivls.push_back(12); ivls.push_back(56);
    send_pkt(0);
    // Timeout with half a '1' pending -> eop and err together.
    add_preamble(16); add_bit(1'b0); add_bit(1'b1); ivls.push_back(20); send_pkt(0);
    // rx_en drop mid-DATA, then relock.
    add_preamble(16); add_bit(1'b0); add_bit(1'b1); send_pkt(1);
    add_preamble(16); add_bit(1'b1); add_bit(1'b0); send_pkt(0);
    // rstz pulse mid-DATA, then relock.
    add_preamble(16); add_bit(1'b1); add_bit(1'b1); send_pkt(2);
    add_preamble(16); add_bit(1'b0); add_bit(1'b0); send_pkt(0);

    // Randomized packets with jitter and occasional bad intervals.
    jit = 1'b1;
    for (int p = 0; p < 10; p++) begin
      int nb, pos, mode;
      add_preamble(16);
      nb = 8 + int'($urandom_range(16));
      for (int i = 0; i < nb; i++) add_bit(1'($urandom_range(1)));
      if ($urandom_range(2) == 0) begin
        pos = int'($urandom_range(ivls.size() - 1));
        ivls.insert(pos, 4 + int'($urandom_range(71)));
      end
      if ($urandom_range(3) == 0) ivls.push_back(20);
      mode = ($urandom_range(4) == 0) ? 1 + int'($urandom_range(1)) : 0;
      send_pkt(mode);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bmc_rx.md
BMC_RX -- requirements
Module: bmc_rx

Interface
REQ-001 Parameter T_MIN, default 12: minimum legal edge interval in clk cycles.
REQ-002 Parameter T_SPLIT, default 30: intervals below this are half-UI, at or above it are full-UI.
REQ-003 Parameter T_MAX, default 56: maximum legal edge interval in clk cycles.
REQ-004 Parameter T_IDLE, default 64: edge-free cycles that end reception.
REQ-005 Parameter N_LOCK, default 8: consecutive legal intervals required to lock.
REQ-006 clk  input  1  receive clock, 12 MHz nominal (UI at 300 kbps is about 40 clk).
REQ-007 rstz  input  1  reset, asynchronous and active-low.
REQ-008 comp_cc  input  1  asynchronous CC comparator output (v_CC > 550 mV).
REQ-009 rx_en  input  1  receiver enable.
REQ-010 rx_bit  output  1  decoded bit value.
REQ-011 rx_bit_vld  output  1  one-cycle strobe qualifying rx_bit.
REQ-012 rx_eop  output  1  one-cycle strobe marking the end of a locked reception.
REQ-013 rx_err  output  1  one-cycle strobe marking a decode error.
REQ-014 rx_active  output  1  high while the state is TRAIN or DATA.
REQ-015 cc_idle  output  1  high while the state is IDLE.

Function
REQ-016 comp_cc SHALL pass through a 2-FF synchronizer; an edge is any change of the synchronized value from the previous cycle.
REQ-017 The interval counter SHALL be 7 bits, saturate at 127, load 1 on each edge, and increment otherwise.
REQ-018 The FSM SHALL have the states IDLE, TRAIN and DATA.
REQ-019 IDLE -> TRAIN on the first edge while rx_en=1; hcnt and pend are cleared.
REQ-020 In TRAIN, an interval in the range T_MIN..T_MAX SHALL increment the lock count; an illegal interval SHALL reset the lock count to 0 without raising rx_err.
REQ-021 TRAIN -> DATA on the edge that completes N_LOCK consecutive legal intervals; pend=0 on entry; no bits are output in TRAIN.
REQ-022 In DATA, at each edge, an interval in the range T_SPLIT..T_MAX SHALL output bit 0.
REQ-023 In DATA, at each edge, an interval in the range T_MIN..T_SPLIT-1 with pend=0 SHALL set pend.
REQ-024 In DATA, at each edge, an interval in the range T_MIN..T_SPLIT-1 with pend=1 SHALL output bit 1 and clear pend.
REQ-025 A full-UI interval with pend=1 SHALL raise rx_err and return the FSM to IDLE.
REQ-026 In DATA, an interval below T_MIN or above T_MAX SHALL raise rx_err and return the FSM to IDLE; no bit is output.
REQ-027 Idle timeout: when the counter reaches T_IDLE with no edge, TRAIN -> IDLE silently.
REQ-028 Idle timeout in DATA SHALL return to IDLE with an rx_eop pulse, plus an rx_err pulse in the same cycle if pend=1.
REQ-029 rx_en=0 SHALL force IDLE on the next clk, clear pend and the lock count, and emit no rx_eop or rx_err.
REQ-030 Outputs SHALL be registered; rx_bit_vld SHALL rise at the 3rd rising clk after the comp_cc transition that completes the bit (2 sync stages + 1 decode).
REQ-031 An edge coincident with the timeout cycle SHALL be treated as an edge; the timeout is ignored.
REQ-032 rx_bit_vld, rx_eop and rx_err SHALL each be high for at most one cycle per event and never while in IDLE.

Reset
REQ-033 With rstz=0, all state SHALL clear asynchronously: FSM=IDLE, sync FFs=0, counter=0, lock count=0, pend=0.
REQ-034 Reset values: rx_bit=0, rx_bit_vld=0, rx_eop=0, rx_err=0, rx_active=0, cc_idle=1.
REQ-035 Reset asserted mid-packet SHALL produce no rx_eop or rx_err; after release, the first synchronized edge starts TRAIN.

Structure
REQ-036 The shared package bmc_rx_pkg SHALL hold the state encoding (IDLE=2'd0, TRAIN=2'd1, DATA=2'd2), the default thresholds, and the counter width.
REQ-037 The synchronizer SHALL be the sub-module cc_sync (2-FF, asynchronous active-low reset, reset value 0); all other logic is in bmc_rx.

Verification
REQ-038 Hold rstz=0 with comp_cc toggling -> cc_idle=1, rx_active=0, no strobes.
REQ-039 Preamble of 64 alternating bits at UI=40 clk -> DATA after the 8th legal interval; rx_bit sequence alternates; rx_bit_vld 3 clk after each completing transition.
REQ-040 In DATA, intervals 40, then 20, 20 -> rx_bit 0, then 1; intervals 20, 40 -> rx_err, IDLE.
REQ-041 In DATA, interval 8 -> rx_err; in a fresh packet, interval 60 -> rx_err; FSM=IDLE after each.
REQ-042 Last edge, then 64 clk quiet -> single rx_eop, cc_idle=1 on the next clk; same with pend=1 -> rx_eop and rx_err together.
REQ-043 rx_en 1 -> 0 mid-DATA, and separately rstz pulse mid-DATA -> IDLE, no rx_eop or rx_err; the next preamble relocks normally.
